vx_dma_scheduler: RTL and testbench

- Shares the single core-level DMA bus between NUM_REQS DMA requesters, e.g. per-issue-slot DMA PEs inside the SFU.
- Arbitrates round-robin, registers the winning request onto the bus, and tracks outstanding transfers per warp.
- Generates the per-warp DMA stall mask consumed by the warp scheduler.
- Sits between the SFU DMA PEs and the DMA engine / memory-side bus port.

---
 rtl/vx_dma_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_vx_dma_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vx_dma_scheduler.sv
// Round-robin arbiter sharing one DMA bus among NUM_REQS requesters, with per-warp outstanding counters and stall mask.
// Optional build macro DMA_SCHED_PERF_EN adds the perf_issued / perf_cap_stalls counter outputs.
module vx_dma_scheduler #(
   parameter int NUM_REQS        = 4,
   parameter int NUM_WARPS       = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int LEN_WIDTH       = 16,
   parameter int MAX_OUTSTANDING = 3,
   localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int RW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQS-1:0]            req_valid,
   output logic [NUM_REQS-1:0]            req_ready,
   input  logic [NUM_REQS*WW-1:0]         req_wid,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_src,
   input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_dst,
   input  logic [NUM_REQS*LEN_WIDTH-1:0]  req_len,
   output logic                           bus_req_valid,
   input  logic                           bus_req_ready,
   output logic [ADDR_WIDTH-1:0]          bus_req_src,
   output logic [ADDR_WIDTH-1:0]          bus_req_dst,
   output logic [LEN_WIDTH-1:0]           bus_req_len,
   output logic [WW-1:0]                  bus_req_tag,
   input  logic                           bus_rsp_valid,
   input  logic [WW-1:0]                  bus_rsp_tag,
   output logic [NUM_WARPS-1:0]           dma_warp_stall,
   output logic                           rsp_error
`ifdef DMA_SCHED_PERF_EN
   ,
   output logic [31:0]                    perf_issued,
   output logic [31:0]                    perf_cap_stalls
`endif
);

   logic [2:0]            cnt_q [NUM_WARPS];
   logic [2:0]            cnt_d [NUM_WARPS];
   logic [RW-1:0]         rr_q, rr_d;
   logic                  bus_valid_q, bus_valid_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [WW-1:0]         tag_q, tag_d;
   logic [NUM_WARPS-1:0]  stall_q, stall_d;
   logic                  err_q, err_d;

   logic [NUM_REQS-1:0]   cap_ok_s, elig_s;
   logic                  found_s, grant_s, win_nz_s;
   logic [RW-1:0]         win_s;
   logic [WW-1:0]         win_wid_s;
   logic [LEN_WIDTH-1:0]  win_len_s;

   // Eligibility: cap compared against the pre-grant count of the requester's warp
   always_comb begin
      for (int i = 0; i < NUM_REQS; i++) begin
         cap_ok_s[i] = (cnt_q[req_wid[i*WW +: WW]] < 3'(MAX_OUTSTANDING));
         elig_s[i]   = req_valid[i] & cap_ok_s[i];
      end
   end

   // Round-robin search from the pointer; grant is blocked while reset is asserted
   always_comb begin : arb
      int idx;
      idx     = 0;
      win_s   = rr_q;
      found_s = 1'b0;
      for (int k = 0; k < NUM_REQS; k++) begin
         idx = (int'(rr_q) + k) % NUM_REQS;
         if (!found_s && elig_s[idx]) begin
            found_s = 1'b1;
            win_s   = RW'(idx);
         end else begin
            found_s = found_s;
         end
      end
      grant_s   = reset & found_s & (~bus_valid_q | bus_req_ready);
      win_wid_s = req_wid[win_s*WW +: WW];
      win_len_s = req_len[win_s*LEN_WIDTH +: LEN_WIDTH];
      win_nz_s  = (win_len_s != {LEN_WIDTH{1'b0}});
      for (int i = 0; i < NUM_REQS; i++) begin
         req_ready[i] = grant_s & (win_s == RW'(i));
      end
   end

   // Next-state: pointer, output register, per-warp counters, stall mask, sticky error
   always_comb begin
      logic inc_s, dec_s, bad_s;
      inc_s       = 1'b0;
      dec_s       = 1'b0;
      bad_s       = 1'b0;
      rr_d        = rr_q;
      bus_valid_d = bus_valid_q;
      src_d       = src_q;
      dst_d       = dst_q;
      len_d       = len_q;
      tag_d       = tag_q;
      err_d       = err_q;
      if (grant_s) begin
         rr_d = (win_s == RW'(NUM_REQS-1)) ? RW'(0) : win_s + RW'(1);
      end else begin
         rr_d = rr_q;
      end
      // Zero-length grants take the slot but never reach the bus
      if (grant_s && win_nz_s) begin
         bus_valid_d = 1'b1;
         src_d       = req_src[win_s*ADDR_WIDTH +: ADDR_WIDTH];
         dst_d       = req_dst[win_s*ADDR_WIDTH +: ADDR_WIDTH];
         len_d       = win_len_s;
         tag_d       = win_wid_s;
      end else if (bus_req_ready) begin
         bus_valid_d = 1'b0;
      end else begin
         bus_valid_d = bus_valid_q;
      end
      for (int w = 0; w < NUM_WARPS; w++) begin
         inc_s = grant_s & win_nz_s & (win_wid_s == WW'(w));
         dec_s = bus_rsp_valid & (bus_rsp_tag == WW'(w));
         bad_s = dec_s & (cnt_q[w] == 3'd0);
         if (bad_s) begin
            err_d = 1'b1;
         end else begin
            err_d = err_d;
         end
         case ({inc_s, dec_s & ~bad_s})
            2'b10:   cnt_d[w] = cnt_q[w] + 3'd1;
            2'b01:   cnt_d[w] = cnt_q[w] - 3'd1;
            default: cnt_d[w] = cnt_q[w];
         endcase
         stall_d[w] = (cnt_d[w] != 3'd0);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q        <= RW'(0);
         bus_valid_q <= 1'b0;
         src_q       <= {ADDR_WIDTH{1'b0}};
         dst_q       <= {ADDR_WIDTH{1'b0}};
         len_q       <= {LEN_WIDTH{1'b0}};
         tag_q       <= {WW{1'b0}};
         stall_q     <= {NUM_WARPS{1'b0}};
         err_q       <= 1'b0;
         for (int w = 0; w < NUM_WARPS; w++) cnt_q[w] <= 3'd0;
      end else begin
         rr_q        <= rr_d;
         bus_valid_q <= bus_valid_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         len_q       <= len_d;
         tag_q       <= tag_d;
         stall_q     <= stall_d;
         err_q       <= err_d;
         for (int w = 0; w < NUM_WARPS; w++) cnt_q[w] <= cnt_d[w];
      end
   end

   assign bus_req_valid  = bus_valid_q;
   assign bus_req_src    = src_q;
   assign bus_req_dst    = dst_q;
   assign bus_req_len    = len_q;
   assign bus_req_tag    = tag_q;
   assign dma_warp_stall = stall_q;
   assign rsp_error      = err_q;

`ifdef DMA_SCHED_PERF_EN
   logic [31:0] perf_issued_q, perf_issued_d, perf_cap_q, perf_cap_d;

   // Perf counters: bus handshakes, and cycles where a valid request is held back only by the cap
   always_comb begin
      perf_issued_d = perf_issued_q + ((bus_valid_q & bus_req_ready) ? 32'd1 : 32'd0);
      perf_cap_d    = perf_cap_q + ((|(req_valid & ~cap_ok_s)) ? 32'd1 : 32'd0);
   end

   // Perf counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_issued_q <= 32'd0;
         perf_cap_q    <= 32'd0;
      end else begin
         perf_issued_q <= perf_issued_d;
         perf_cap_q    <= perf_cap_d;
      end
   end

   assign perf_issued     = perf_issued_q;
   assign perf_cap_stalls = perf_cap_q;
`endif

endmodule

// File: tb/tb_vx_dma_scheduler.sv
// Table-driven bench for vx_dma_scheduler: per-cycle vectors with hand-computed outputs, plus a mid-cycle reset sequence.
module tb_vx_dma_scheduler;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [3:0]   req_valid = 4'd0;
   logic [3:0]   req_ready;
   logic [7:0]   req_wid = 8'd0;
   logic [127:0] req_src, req_dst;
   logic [63:0]  req_len;
   logic         bus_req_valid;
   logic         bus_req_ready = 1'b0;
   logic [31:0]  bus_req_src, bus_req_dst;
   logic [15:0]  bus_req_len;
   logic [1:0]   bus_req_tag;
   logic         bus_rsp_valid = 1'b0;
   logic [1:0]   bus_rsp_tag = 2'd0;
   logic [3:0]   dma_warp_stall;
   logic         rsp_error;
`ifdef DMA_SCHED_PERF_EN
   logic [31:0]  perf_issued, perf_cap_stalls;
`endif

   vx_dma_scheduler dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
      .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_req_src(bus_req_src), .bus_req_dst(bus_req_dst),
      .bus_req_len(bus_req_len), .bus_req_tag(bus_req_tag),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_tag(bus_rsp_tag),
      .dma_warp_stall(dma_warp_stall), .rsp_error(rsp_error)
`ifdef DMA_SCHED_PERF_EN
      , .perf_issued(perf_issued), .perf_cap_stalls(perf_cap_stalls)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] valid;
      logic [7:0] wid;
      logic [3:0] zlen;
      logic       rdy;
      logic       rsp;
      logic [1:0] rtag;
      logic [3:0] e_ready;
      logic       e_bv;
      logic [1:0] e_tag;
      logic [1:0] e_src;
      logic [3:0] e_stall;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic [3:0] valid, input logic [7:0] wid, input logic [3:0] zlen,
                               input logic rdy, input logic rsp, input logic [1:0] rtag,
                               input logic [3:0] e_ready, input logic e_bv, input logic [1:0] e_tag,
                               input logic [1:0] e_src, input logic [3:0] e_stall, input logic e_err);
      vec_t v;
      v.valid = valid; v.wid = wid; v.zlen = zlen; v.rdy = rdy; v.rsp = rsp; v.rtag = rtag;
      v.e_ready = e_ready; v.e_bv = e_bv; v.e_tag = e_tag; v.e_src = e_src;
      v.e_stall = e_stall; v.e_err = e_err;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      req_valid     = v.valid;
      req_wid       = v.wid;
      bus_req_ready = v.rdy;
      bus_rsp_valid = v.rsp;
      bus_rsp_tag   = v.rtag;
      for (int i = 0; i < 4; i++) begin
         req_src[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h100;
         req_dst[i*32 +: 32] = 32'h2000 + 32'(i) * 32'h100;
         req_len[i*16 +: 16] = v.zlen[i] ? 16'd0 : 16'd64;
      end
   endtask

   initial begin
      vec_t idle;
      // Round-robin: reqs 0..3 on warps 0..3, then drain
      vecs.push_back(mk(4'hF, 8'hE4, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      vecs.push_back(mk(4'hF, 8'hE4, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd0, 2'd0, 4'b0001, 1'b0));
      vecs.push_back(mk(4'hF, 8'hE4, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd1, 2'd1, 4'b0011, 1'b0));
      vecs.push_back(mk(4'hF, 8'hE4, 4'h0, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd2, 2'd2, 4'b0111, 1'b0));
      vecs.push_back(mk(4'hF, 8'hE4, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd3, 2'd3, 4'b1111, 1'b0));
      vecs.push_back(mk(4'h0, 8'hE4, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd0, 2'd0, 4'b1111, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b1111, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b1110, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b1100, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b1000, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      // Single request: req 0, warp 2
      vecs.push_back(mk(4'h1, 8'h02, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd2, 2'd0, 4'b0100, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0100, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      // Backpressure: 5 cycles of bus_req_ready low
      vecs.push_back(mk(4'h2, 8'h04, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(4'h3, 8'h04, 4'h0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 2'd1, 4'b0010, 1'b0));
      vecs.push_back(mk(4'h3, 8'h04, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd1, 2'd1, 4'b0010, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 2'd0, 4'b0011, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0011, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0010, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      // Outstanding cap: req 2 on warp 1 fills to 3, req 0 on warp 0 still proceeds
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(4'h4, 8'h10, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0100, (k != 0), 2'd1, 2'd2,
                           (k == 0) ? 4'b0000 : 4'b0010, 1'b0));
      vecs.push_back(mk(4'h5, 8'h10, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd1, 2'd2, 4'b0010, 1'b0));
      vecs.push_back(mk(4'h4, 8'h10, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 2'd0, 4'b0011, 1'b0));
      vecs.push_back(mk(4'h4, 8'h10, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0011, 1'b0));
      vecs.push_back(mk(4'h4, 8'h10, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b0, 2'd0, 2'd0, 4'b0011, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 2'd1, 2'd2, 4'b0011, 1'b0));
      for (int k = 0; k < 3; k++)
         vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0010, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      // Grant and response for warp 3 in the same cycle with cnt=1
      vecs.push_back(mk(4'h8, 8'hC0, 4'h0, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      vecs.push_back(mk(4'h8, 8'hC0, 4'h0, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 2'd3, 2'd3, 4'b1000, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd3, 2'd3, 4'b1000, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b1000, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      // Zero-length request: acknowledged, no bus request, pointer still advances
      vecs.push_back(mk(4'h1, 8'h00, 4'h1, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      vecs.push_back(mk(4'h3, 8'h04, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 2'd1, 4'b0010, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0010, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      // Completion for idle warp 0: sticky error, counter stays 0
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b1));
      vecs.push_back(mk(4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b1));

      idle = mk(4'h0, 8'h00, 4'h0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000, 1'b0);
      apply(idle);
      repeat (3) @(negedge clk);
      check("reset bus_valid", 32'(bus_req_valid), 32'd0);
      check("reset stall", 32'(dma_warp_stall), 32'd0);
      check("reset err", 32'(rsp_error), 32'd0);
      check("reset tag", 32'(bus_req_tag), 32'd0);
      reset = 1'b1;

      foreach (vecs[n]) begin
         @(posedge clk);
         #1 apply(vecs[n]);
         @(negedge clk);
         check($sformatf("v%0d ready", n), 32'(req_ready), 32'(vecs[n].e_ready));
         check($sformatf("v%0d bus_valid", n), 32'(bus_req_valid), 32'(vecs[n].e_bv));
         check($sformatf("v%0d stall", n), 32'(dma_warp_stall), 32'(vecs[n].e_stall));
         check($sformatf("v%0d err", n), 32'(rsp_error), 32'(vecs[n].e_err));
         if (vecs[n].e_bv) begin
            check($sformatf("v%0d tag", n), 32'(bus_req_tag), 32'(vecs[n].e_tag));
            check($sformatf("v%0d src", n), bus_req_src, 32'h1000 + 32'(vecs[n].e_src) * 32'h100);
            check($sformatf("v%0d dst", n), bus_req_dst, 32'h2000 + 32'(vecs[n].e_src) * 32'h100);
            check($sformatf("v%0d len", n), 32'(bus_req_len), 32'd64);
         end
      end

      // Mid-cycle reset with bus_req_valid=1 and cnt[2]=2 (pointer is at 2 here)
      @(posedge clk);
      #1 apply(mk(4'h4, 8'h20, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #1 bus_req_ready = 1'b0;
      @(negedge clk);
      check("pre-reset bus_valid", 32'(bus_req_valid), 32'd1);
      check("pre-reset stall", 32'(dma_warp_stall), 32'b0100);
      check("pre-reset ready", 32'(req_ready), 32'd0);
      #1 reset = 1'b0;
      #1;
      check("async reset bus_valid", 32'(bus_req_valid), 32'd0);
      check("async reset stall", 32'(dma_warp_stall), 32'd0);
      check("async reset err", 32'(rsp_error), 32'd0);
      check("async reset ready", 32'(req_ready), 32'd0);
      check("async reset src", bus_req_src, 32'd0);
      apply(idle);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 begin bus_rsp_valid = 1'b1; bus_rsp_tag = 2'd2; end
      @(negedge clk);
      check("late rsp err before edge", 32'(rsp_error), 32'd0);
      @(posedge clk);
      #1 bus_rsp_valid = 1'b0;
      @(negedge clk);
      check("late rsp err", 32'(rsp_error), 32'd1);
      check("late rsp stall", 32'(dma_warp_stall), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
